usb2_ep_router: RTL

- Parametrised endpoint router between the USB 2.0 packet layer and NUM_EP endpoint buffers.
- Replaces the fixed five-endpoint select-and-mux with a registered endpoint select and per-endpoint modes from a parameter.
- Adds a handshake FSM that locks the selection while a commit or arm is outstanding, an ack timeout, and per-endpoint halt.
- Sits between the packet layer and the usb2_ep0/usb2_ep instances inside the protocol layer.

---
 rtl/usb2_pkg.sv | 22 ++
 rtl/usb2_ep_handshake.sv | 103 ++++++++++
 rtl/usb2_ep_router.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/usb2_pkg.sv
// Shared constants for the USB 2.0 endpoint router: endpoint transfer modes,
// handshake FSM state encoding and the default five-endpoint mode table.
package usb2_pkg;

  localparam logic [1:0] EP_MODE_CONTROL   = 2'd0;
  localparam logic [1:0] EP_MODE_ISOCH     = 2'd1;
  localparam logic [1:0] EP_MODE_BULK      = 2'd2;
  localparam logic [1:0] EP_MODE_INTERRUPT = 2'd3;

  localparam int DEF_NUM_EP = 5;

  // EP0 occupies the least-significant pair.
  localparam logic [2*DEF_NUM_EP-1:0] EP_MODES_DEFAULT =
    {EP_MODE_BULK, EP_MODE_ISOCH, EP_MODE_BULK, EP_MODE_BULK, EP_MODE_CONTROL};

  typedef enum logic [1:0] {
    HS_IDLE      = 2'd0,
    HS_WAIT_CACK = 2'd1,
    HS_WAIT_AACK = 2'd2
  } hs_state_t;

endpackage

// File: rtl/usb2_ep_handshake.sv
// Single outstanding commit/arm request: holds the request level until the
// endpoint acks or the timeout expires, and flags requests to unusable endpoints.
module usb2_ep_handshake
  import usb2_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  logic phy_clk,
  input  logic reset_n,
  input  logic commit,
  input  logic arm,
  input  logic ep_ok,
  input  logic ep_commit_ack,
  input  logic ep_arm_ack,
  output logic busy,
  output logic lock,
  output logic req_commit,
  output logic req_arm,
  output logic commit_ack,
  output logic arm_ack,
  output logic err_timeout,
  output logic err_halted
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  hs_state_t        state;
  logic [CNT_W-1:0] cnt;

  assign busy = (state != HS_IDLE);
  // The selection must also freeze on the edge that accepts a new request.
  assign lock = busy | ((commit | arm) & ep_ok);

  always_ff @(posedge phy_clk) begin
    if (!reset_n) begin
      state       <= HS_IDLE;
      cnt         <= '0;
      req_commit  <= 1'b0;
      req_arm     <= 1'b0;
      commit_ack  <= 1'b0;
      arm_ack     <= 1'b0;
      err_timeout <= 1'b0;
      err_halted  <= 1'b0;
    end else begin
      commit_ack  <= 1'b0;
      arm_ack     <= 1'b0;
      err_timeout <= 1'b0;
      err_halted  <= 1'b0;
      case (state)
        HS_IDLE: begin
          cnt <= '0;
          if (commit && ep_ok) begin
            state      <= HS_WAIT_CACK;
            req_commit <= 1'b1;
          end else if (arm && ep_ok) begin
            state   <= HS_WAIT_AACK;
            req_arm <= 1'b1;
          end else if (commit || arm) begin
            err_halted <= 1'b1;
          end
        end
        HS_WAIT_CACK: begin
          if (ep_commit_ack) begin
            req_commit <= 1'b0;
            commit_ack <= 1'b1;
            state      <= HS_IDLE;
            cnt        <= '0;
          end else if (cnt == TMO) begin
            req_commit  <= 1'b0;
            err_timeout <= 1'b1;
            state       <= HS_IDLE;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HS_WAIT_AACK: begin
          if (ep_arm_ack) begin
            req_arm <= 1'b0;
            arm_ack <= 1'b1;
            state   <= HS_IDLE;
            cnt     <= '0;
          end else if (cnt == TMO) begin
            req_arm     <= 1'b0;
            err_timeout <= 1'b1;
            state       <= HS_IDLE;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state      <= HS_IDLE;
          req_commit <= 1'b0;
          req_arm    <= 1'b0;
          cnt        <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/usb2_ep_router.sv
// Routes the packet-layer buffer bus to one of NUM_EP endpoints with a registered
// select, per-endpoint halt and a locked handshake. Optional USB2_EP_ROUTER_STATS_EN adds ack counters.
module usb2_ep_router
  import usb2_pkg::*;
#(
  parameter int                    NUM_EP   = 5,
  parameter int                    EP_W     = 4,
  parameter logic [2*NUM_EP-1:0]   EP_MODES = EP_MODES_DEFAULT,
  parameter int                    TIMEOUT  = 1023
) (
  input  logic                   phy_clk,
  input  logic                   reset_n,
`ifdef USB2_EP_ROUTER_STATS_EN
  input  logic [EP_W-1:0]        stat_sel,
  output logic [15:0]            stat_count,
`endif
  input  logic [EP_W-1:0]        sel_endp,
  input  logic [10:0]            buf_in_addr,
  input  logic [7:0]             buf_in_data,
  input  logic                   buf_in_wren,
  input  logic                   buf_in_commit,
  input  logic [10:0]            buf_in_commit_len,
  output logic                   buf_in_ready,
  output logic                   buf_in_commit_ack,
  input  logic [10:0]            buf_out_addr,
  input  logic                   buf_out_arm,
  output logic [7:0]             buf_out_q,
  output logic [10:0]            buf_out_len,
  output logic                   buf_out_hasdata,
  output logic                   buf_out_arm_ack,
  input  logic                   data_toggle_act,
  output logic [1:0]             data_toggle,
  output logic [1:0]             endp_mode,
  output logic [11*NUM_EP-1:0]   ep_buf_in_addr,
  output logic [8*NUM_EP-1:0]    ep_buf_in_data,
  output logic [NUM_EP-1:0]      ep_buf_in_wren,
  output logic [NUM_EP-1:0]      ep_buf_in_commit,
  output logic [11*NUM_EP-1:0]   ep_buf_in_commit_len,
  input  logic [NUM_EP-1:0]      ep_buf_in_ready,
  input  logic [NUM_EP-1:0]      ep_buf_in_commit_ack,
  output logic [11*NUM_EP-1:0]   ep_buf_out_addr,
  output logic [NUM_EP-1:0]      ep_buf_out_arm,
  input  logic [NUM_EP-1:0]      ep_buf_out_arm_ack,
  input  logic [8*NUM_EP-1:0]    ep_buf_out_q,
  input  logic [11*NUM_EP-1:0]   ep_buf_out_len,
  input  logic [NUM_EP-1:0]      ep_buf_out_hasdata,
  output logic [NUM_EP-1:0]      ep_data_toggle_act,
  input  logic [2*NUM_EP-1:0]    ep_data_toggle,
  input  logic [NUM_EP-1:0]      halt_set,
  input  logic [NUM_EP-1:0]      halt_clr,
  output logic [NUM_EP-1:0]      ep_halted,
  output logic                   err_timeout,
  output logic                   err_halted
);

  localparam logic [EP_W:0] NUM_EP_CMP = (EP_W + 1)'(NUM_EP);

  logic [EP_W-1:0]   sel_q;
  logic              valid_q;
  logic [NUM_EP-1:0] halt;
  logic [NUM_EP-1:0] sel_oh;
  logic              sel_halt;
  logic              hs_busy;
  logic              hs_lock;
  logic              req_commit;
  logic              req_arm;
  logic [10:0]       len_q;

  always_ff @(posedge phy_clk) begin
    if (!reset_n) begin
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else if (!hs_lock) begin
      sel_q   <= sel_endp;
      valid_q <= ({1'b0, sel_endp} < NUM_EP_CMP);
    end
  end

  // Set has priority over clear.
  always_ff @(posedge phy_clk) begin
    if (!reset_n) halt <= '0;
    else          halt <= (halt & ~halt_clr) | halt_set;
  end

  assign ep_halted = halt;

  always_ff @(posedge phy_clk) begin
    if (!hs_busy && buf_in_commit) len_q <= buf_in_commit_len;
  end

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_EP; i++) sel_oh[i] = valid_q && (sel_q == EP_W'(i));
  end

  assign sel_halt = |(sel_oh & halt);

  usb2_ep_handshake #(
    .TIMEOUT (TIMEOUT)
  ) u_hs (
    .phy_clk       (phy_clk),
    .reset_n       (reset_n),
    .commit        (buf_in_commit),
    .arm           (buf_out_arm),
    .ep_ok         (valid_q & ~sel_halt),
    .ep_commit_ack (|(sel_oh & ep_buf_in_commit_ack)),
    .ep_arm_ack    (|(sel_oh & ep_buf_out_arm_ack)),
    .busy          (hs_busy),
    .lock          (hs_lock),
    .req_commit    (req_commit),
    .req_arm       (req_arm),
    .commit_ack    (buf_in_commit_ack),
    .arm_ack       (buf_out_arm_ack),
    .err_timeout   (err_timeout),
    .err_halted    (err_halted)
  );

  always_comb begin
    ep_buf_in_addr       = '0;
    ep_buf_in_data       = '0;
    ep_buf_in_wren       = '0;
    ep_buf_in_commit     = '0;
    ep_buf_in_commit_len = '0;
    ep_buf_out_addr      = '0;
    ep_buf_out_arm       = '0;
    ep_data_toggle_act   = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (sel_oh[i]) begin
        ep_buf_in_addr[11*i +: 11]       = buf_in_addr;
        ep_buf_in_data[8*i +: 8]         = buf_in_data;
        ep_buf_in_wren[i]                = buf_in_wren & ~halt[i];
        ep_buf_in_commit[i]              = req_commit;
        ep_buf_in_commit_len[11*i +: 11] = req_commit ? len_q : 11'd0;
        ep_buf_out_addr[11*i +: 11]      = buf_out_addr;
        ep_buf_out_arm[i]                = req_arm;
        ep_data_toggle_act[i]            = data_toggle_act;
      end
    end
  end

  always_comb begin
    buf_out_q       = '0;
    buf_out_len     = '0;
    buf_out_hasdata = 1'b0;
    buf_in_ready    = 1'b0;
    data_toggle     = '0;
    endp_mode       = EP_MODE_CONTROL;
    for (int i = 0; i < NUM_EP; i++) begin
      if (sel_oh[i]) begin
        buf_out_q       = ep_buf_out_q[8*i +: 8];
        buf_out_len     = ep_buf_out_len[11*i +: 11];
        buf_out_hasdata = ep_buf_out_hasdata[i];
        buf_in_ready    = ep_buf_in_ready[i];
        data_toggle     = ep_data_toggle[2*i +: 2];
        endp_mode       = EP_MODES[2*i +: 2];
      end
    end
    // A halted endpoint must look empty and not ready to the packet layer.
    if (sel_halt) begin
      buf_out_hasdata = 1'b0;
      buf_in_ready    = 1'b0;
    end
  end

`ifdef USB2_EP_ROUTER_STATS_EN
  logic [15:0] stat_cnt [NUM_EP];
  logic        ack_evt;

  // The select is still frozen during the ack pulse cycle, so sel_oh names the acked endpoint.
  assign ack_evt = buf_in_commit_ack | buf_out_arm_ack;

  always_ff @(posedge phy_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_EP; i++) stat_cnt[i] <= '0;
      stat_count <= '0;
    end else begin
      for (int i = 0; i < NUM_EP; i++) begin
        if (ack_evt && sel_oh[i] && (stat_cnt[i] != 16'hFFFF)) stat_cnt[i] <= stat_cnt[i] + 16'd1;
      end
      stat_count <= '0;
      for (int i = 0; i < NUM_EP; i++) begin
        if (stat_sel == EP_W'(i)) stat_count <= stat_cnt[i];
      end
    end
  end
`endif

endmodule
